// File: rtl/dna_revcomp_stream.sv
// Store-and-forward DNA word buffer with per-sequence replay transform.
// Modes: pass, complement, reverse, reverse-complement.
module dna_revcomp_stream #(
    parameter int N     = 4,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 mode,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2*N-1:0]             in_data,
    input  logic                       in_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2*N-1:0]             out_data,
    output logic                       out_last,
    output logic [$clog2(DEPTH+1)-1:0] seq_len,
    output logic                       ovf,
    output logic                       busy
);

    localparam int W  = 2 * N;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_DRAIN
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     mode_q, mode_d;
    logic [LW-1:0]  len_q, len_d;
    logic [LW-1:0]  rem_q, rem_d;
    logic [PW-1:0]  rd_q, rd_d;
    logic           ov_q, ov_d;
    logic [W-1:0]   od_q, od_d;
    logic           ol_q, ol_d;
    logic           ovf_q, ovf_d;
    logic [W-1:0]   mem [DEPTH];
    logic           mem_we;
    logic           acc, oxfer, close;
    logic [1:0]     mode_eff;
    logic [W-1:0]   first_w;

    function automatic logic [W-1:0] xform(
        input logic [W-1:0] w,
        input logic [1:0]   m
    );
        logic [W-1:0] r;
        r = w;
        if (m[1]) begin
            for (int i = 0; i < N; i++) begin
                r[2*i +: 2] = w[2*(N-1-i) +: 2];
            end
        end
        if (m[0]) begin
            for (int i = 0; i < N; i++) begin
                r[2*i] = ~r[2*i];
            end
        end
        return r;
    endfunction

    assign in_ready  = !rst && (state_q != S_DRAIN);
    assign acc       = in_valid && in_ready;
    assign oxfer     = ov_q && out_ready;
    assign mode_eff  = (state_q == S_IDLE) ? mode : mode_q;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        len_d   = len_q;
        rem_d   = rem_q;
        rd_d    = rd_q;
        ov_d    = ov_q;
        od_d    = od_q;
        ol_d    = ol_q;
        ovf_d   = 1'b0;
        mem_we  = 1'b0;
        close   = 1'b0;
        first_w = in_data;
        unique case (state_q)
            S_IDLE: begin
                if (acc) begin
                    mem_we  = 1'b1;
                    mode_d  = mode;
                    len_d   = LW'(1);
                    close   = in_last;
                    state_d = in_last ? S_DRAIN : S_FILL;
                end
            end
            S_FILL: begin
                if (acc) begin
                    mem_we = 1'b1;
                    len_d  = len_q + LW'(1);
                    if (in_last) begin
                        close = 1'b1;
                    end else if (len_q == LW'(DEPTH - 1)) begin
                        close = 1'b1;
                        ovf_d = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (oxfer) begin
                    if (rem_q == '0) begin
                        ov_d    = 1'b0;
                        ol_d    = 1'b0;
                        od_d    = '0;
                        len_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        od_d  = xform(mem[rd_q], mode_q);
                        ol_d  = (rem_q == LW'(1));
                        rem_d = rem_q - LW'(1);
                        rd_d  = mode_q[1] ? rd_q - PW'(1)
                                          : rd_q + PW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Closing beat: its word may be the first replayed, so bypass mem.
        if (close) begin
            state_d = S_DRAIN;
            ov_d    = 1'b1;
            ol_d    = (len_q == '0);
            rem_d   = len_q;
            if (!mode_eff[1] && state_q != S_IDLE) begin
                first_w = mem[0];
            end
            od_d = xform(first_w, mode_eff);
            rd_d = mode_eff[1] ? PW'(len_q - LW'(1)) : PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            rd_q    <= '0;
            ov_q    <= 1'b0;
            od_q    <= '0;
            ol_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            rd_q    <= rd_d;
            ov_q    <= ov_d;
            od_q    <= od_d;
            ol_q    <= ol_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[len_q[PW-1:0]] <= in_data;
        end
    end

    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign out_last  = ol_q;
    assign seq_len   = len_q;
    assign ovf       = ovf_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dna_revcomp_stream.sv
// Directed bench for dna_revcomp_stream (N=4, DEPTH=4).
// Expected words are hand-computed transforms of the driven inputs.
module tb_dna_revcomp_stream;

    logic       clk;
    logic       rst;
    logic [1:0] mode;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic [2:0] seq_len;
    logic       ovf;
    logic       busy;

    int checks = 0;
    int errors = 0;

    dna_revcomp_stream #(.N(4), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .seq_len   (seq_len),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] m, input logic [7:0] d,
                        input logic l);
        mode     = m;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        chk("send_rdy", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] d,
                              input logic l);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_v"}, 32'(out_valid), 32'd1);
        chk({tag, "_d"}, 32'(out_data), 32'(d));
        chk({tag, "_l"}, 32'(out_last), 32'(l));
        tick();
    endtask

    initial begin
        clk       = 1'b0;
        rst       = 1'b1;
        mode      = 2'b00;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_rdy", 32'(in_ready), 32'd0);
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_od", 32'(out_data), 32'd0);
        chk("rst_ol", 32'(out_last), 32'd0);
        chk("rst_len", 32'(seq_len), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk("idle_rdy", 32'(in_ready), 32'd1);

        // complement, single word, latency and DRAIN status
        chk("c1_pre_ov", 32'(out_valid), 32'd0);
        send(2'b01, 8'h1B, 1'b1);
        chk("c1_ov", 32'(out_valid), 32'd1);
        chk("c1_len", 32'(seq_len), 32'd1);
        chk("c1_busy", 32'(busy), 32'd1);
        chk("c1_rdy", 32'(in_ready), 32'd0);
        expect_out("c1", 8'h4E, 1'b1);
        chk("c1_end_ov", 32'(out_valid), 32'd0);
        chk("c1_end_len", 32'(seq_len), 32'd0);
        chk("c1_end_rdy", 32'(in_ready), 32'd1);

        send(2'b10, 8'h1B, 1'b1);
        expect_out("r1", 8'hE4, 1'b1);
        send(2'b11, 8'h1B, 1'b1);
        expect_out("rc1", 8'hB1, 1'b1);
        send(2'b00, 8'h1B, 1'b1);
        expect_out("p1", 8'h1B, 1'b1);

        // two-word revcomp; mode change on beat 2 must be ignored
        send(2'b11, 8'h1B, 1'b0);
        chk("rc2_busy", 32'(busy), 32'd1);
        send(2'b00, 8'h00, 1'b1);
        chk("rc2_len", 32'(seq_len), 32'd2);
        chk("rc2_rdy0", 32'(in_ready), 32'd0);
        expect_out("rc2a", 8'h55, 1'b0);
        chk("rc2_rdy1", 32'(in_ready), 32'd0);
        expect_out("rc2b", 8'hB1, 1'b1);

        // overflow at DEPTH=4
        send(2'b00, 8'h01, 1'b0);
        send(2'b00, 8'h02, 1'b0);
        send(2'b00, 8'h03, 1'b0);
        chk("ovf_pre", 32'(ovf), 32'd0);
        send(2'b00, 8'h04, 1'b0);
        chk("ovf_pulse", 32'(ovf), 32'd1);
        chk("ovf_len", 32'(seq_len), 32'd4);
        chk("ovf_rdy", 32'(in_ready), 32'd0);
        in_data  = 8'h05;
        in_last  = 1'b1;
        in_valid = 1'b1;
        expect_out("ov1", 8'h01, 1'b0);
        chk("ovf_drop", 32'(ovf), 32'd0);
        expect_out("ov2", 8'h02, 1'b0);
        expect_out("ov3", 8'h03, 1'b0);
        expect_out("ov4", 8'h04, 1'b1);
        chk("ov_idle_rdy", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("ov5_len", 32'(seq_len), 32'd1);
        expect_out("ov5", 8'h05, 1'b1);

        // backpressure
        out_ready = 1'b0;
        send(2'b00, 8'hAA, 1'b0);
        send(2'b00, 8'hCC, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("bp_v", 32'(out_valid), 32'd1);
            chk("bp_d", 32'(out_data), 32'h000000AA);
            tick();
        end
        expect_out("bp1", 8'hAA, 1'b0);
        expect_out("bp2", 8'hCC, 1'b1);
        chk("bp_end", 32'(out_valid), 32'd0);

        // reset mid-DRAIN
        out_ready = 1'b0;
        send(2'b00, 8'h11, 1'b0);
        send(2'b00, 8'h22, 1'b0);
        send(2'b00, 8'h33, 1'b1);
        chk("rd_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rd_ov", 32'(out_valid), 32'd0);
        chk("rd_len", 32'(seq_len), 32'd0);
        chk("rd_busy0", 32'(busy), 32'd0);
        chk("rd_rdy", 32'(in_ready), 32'd0);
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("rd_noout", 32'(out_valid), 32'd0);
        send(2'b01, 8'h00, 1'b1);
        expect_out("rd_new", 8'h55, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
